// File: rtl/input_arbiter.sv
// Four-button input arbiter: accepts one debounced press per round, flags
// multi-presses and inactivity timeouts, and hands the result over a valid/ack pair.
module input_arbiter #(
   parameter int unsigned TIMEOUT_TICKS = 10000
) (
   input  logic       clk_2k,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [3:0] btn,
   input  logic       evt_ack,
   output logic       evt_valid,
   output logic [1:0] evt_btn,
   output logic       evt_multi,
   output logic       evt_timeout,
   output logic [3:0] led_echo,
   output logic       busy
);

   localparam int unsigned NBTN = 4;
   localparam int unsigned IW   = 2;
   localparam int unsigned PW   = 3;
   localparam int unsigned TW   = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_TICKS - 1);

   typedef enum logic [1:0] {
      WAIT_REL = 2'd0,
      ARMED    = 2'd1,
      HOLD     = 2'd2,
      REPORT   = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            sticky_q, sticky_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            evt_valid_q, evt_valid_d;
   logic [IW-1:0]   evt_btn_q, evt_btn_d;
   logic            evt_multi_q, evt_multi_d;
   logic            evt_timeout_q, evt_timeout_d;
   logic [NBTN-1:0] led_q, led_d;
   logic            busy_q, busy_d;

   logic [PW-1:0]   pop_c;
   logic [IW-1:0]   low_idx_c;

   // Population count and lowest pressed index of the sampled buttons.
   always_comb begin
      pop_c     = '0;
      low_idx_c = '0;
      for (int i = 0; i < NBTN; i++) begin
         pop_c = pop_c + PW'(btn[i]);
      end
      for (int i = NBTN - 1; i >= 0; i--) begin
         if (btn[i]) low_idx_c = IW'(i);
      end
   end

   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      sticky_d      = sticky_q;
      idx_d         = idx_q;
      evt_valid_d   = evt_valid_q;
      evt_btn_d     = evt_btn_q;
      evt_multi_d   = evt_multi_q;
      evt_timeout_d = evt_timeout_q;
      led_d         = led_q;

      case (state_q)
         WAIT_REL: begin
            timer_d = '0;
            if (btn == '0) begin
               state_d  = ARMED;
               sticky_d = 1'b0;
            end
         end
         ARMED: begin
            if (!enable) begin
               timer_d = '0;
            end else if (pop_c == PW'(1)) begin
               state_d  = HOLD;
               idx_d    = low_idx_c;
               led_d    = btn;
               timer_d  = '0;
               sticky_d = 1'b0;
            end else if (pop_c >= PW'(2)) begin
               state_d       = REPORT;
               evt_valid_d   = 1'b1;
               evt_btn_d     = low_idx_c;
               evt_multi_d   = 1'b1;
               evt_timeout_d = 1'b0;
               timer_d       = '0;
            end else if (timer_q == T_LAST) begin
               // Timeout only fires when no press arrives on the same edge.
               state_d       = REPORT;
               evt_valid_d   = 1'b1;
               evt_btn_d     = '0;
               evt_multi_d   = 1'b0;
               evt_timeout_d = 1'b1;
               timer_d       = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         HOLD: begin
            if (btn == '0) begin
               state_d       = REPORT;
               evt_valid_d   = 1'b1;
               evt_btn_d     = idx_q;
               evt_multi_d   = sticky_q;
               evt_timeout_d = 1'b0;
               led_d         = '0;
            end else if ((btn & ~led_q) != '0) begin
               sticky_d = 1'b1;
            end
         end
         REPORT: begin
            if (evt_ack && evt_valid_q) begin
               state_d       = WAIT_REL;
               evt_valid_d   = 1'b0;
               evt_multi_d   = 1'b0;
               evt_timeout_d = 1'b0;
            end
         end
         default: state_d = WAIT_REL;
      endcase

      busy_d = (state_d != ARMED);
   end

   always_ff @(posedge clk_2k or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= WAIT_REL;
         timer_q       <= '0;
         sticky_q      <= 1'b0;
         idx_q         <= '0;
         evt_valid_q   <= 1'b0;
         evt_btn_q     <= '0;
         evt_multi_q   <= 1'b0;
         evt_timeout_q <= 1'b0;
         led_q         <= '0;
         busy_q        <= 1'b1;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         sticky_q      <= sticky_d;
         idx_q         <= idx_d;
         evt_valid_q   <= evt_valid_d;
         evt_btn_q     <= evt_btn_d;
         evt_multi_q   <= evt_multi_d;
         evt_timeout_q <= evt_timeout_d;
         led_q         <= led_d;
         busy_q        <= busy_d;
      end
   end

   assign evt_valid   = evt_valid_q;
   assign evt_btn     = evt_btn_q;
   assign evt_multi   = evt_multi_q;
   assign evt_timeout = evt_timeout_q;
   assign led_echo    = led_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_input_arbiter.sv
// Directed bench for input_arbiter with a short timeout; expected values hand-computed.
module tb_input_arbiter;

   logic       clk_2k;
   logic       rst_n;
   logic       enable;
   logic [3:0] btn;
   logic       evt_ack;
   logic       evt_valid;
   logic [1:0] evt_btn;
   logic       evt_multi;
   logic       evt_timeout;
   logic [3:0] led_echo;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   input_arbiter #(.TIMEOUT_TICKS(8)) dut (
      .clk_2k      (clk_2k),
      .rst_n       (rst_n),
      .enable      (enable),
      .btn         (btn),
      .evt_ack     (evt_ack),
      .evt_valid   (evt_valid),
      .evt_btn     (evt_btn),
      .evt_multi   (evt_multi),
      .evt_timeout (evt_timeout),
      .led_echo    (led_echo),
      .busy        (busy)
   );

   initial begin
      clk_2k = 1'b0;
      forever #5 clk_2k = ~clk_2k;
   end

   task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk_2k);
   endtask

   task automatic check_evt(input string tag, input logic v, input logic [1:0] b,
                            input logic m, input logic t);
      check_eq({tag, "_valid"},   4'(evt_valid),   4'(v));
      check_eq({tag, "_btn"},     4'(evt_btn),     4'(b));
      check_eq({tag, "_multi"},   4'(evt_multi),   4'(m));
      check_eq({tag, "_timeout"}, 4'(evt_timeout), 4'(t));
   endtask

   initial begin
      rst_n   = 1'b1;
      enable  = 1'b0;
      btn     = 4'b0000;
      evt_ack = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_evt("rst", 1'b0, 2'd0, 1'b0, 1'b0);
      check_eq("rst_led",  led_echo,   4'b0000);
      check_eq("rst_busy", 4'(busy),   4'd1);
      step(2);
      rst_n = 1'b1;
      step(1);
      check_eq("armed_busy", 4'(busy), 4'd0);

      // Enable gating while idle
      btn = 4'b1000;
      step(3);
      check_eq("gate_busy",  4'(busy),      4'd0);
      check_eq("gate_valid", 4'(evt_valid), 4'd0);
      check_eq("gate_led",   led_echo,      4'b0000);
      btn = 4'b0000;

      // Single press on button 2 held for 5 cycles
      enable = 1'b1;
      btn    = 4'b0100;
      step(1);
      check_eq("single_led",  led_echo, 4'b0100);
      check_eq("single_busy", 4'(busy), 4'd1);
      step(4);
      check_eq("single_led_hold", led_echo,      4'b0100);
      check_eq("single_noevt",    4'(evt_valid), 4'd0);
      btn = 4'b0000;
      step(1);
      check_evt("single", 1'b1, 2'd2, 1'b0, 1'b0);
      check_eq("single_led_off", led_echo, 4'b0000);
      evt_ack = 1'b1;
      step(1);
      check_eq("single_ack_valid", 4'(evt_valid), 4'd0);
      check_eq("single_ack_btn",   4'(evt_btn),   4'd2);
      check_eq("single_waitrel",   4'(busy),      4'd1);
      evt_ack = 1'b0;
      step(1);
      check_eq("single_rearm", 4'(busy), 4'd0);

      // Simultaneous press
      btn = 4'b0110;
      step(1);
      check_evt("simul", 1'b1, 2'd1, 1'b1, 1'b0);
      evt_ack = 1'b1;
      btn     = 4'b0000;
      step(1);
      check_eq("simul_ack", 4'(evt_valid), 4'd0);
      evt_ack = 1'b0;
      step(1);

      // Second press during HOLD
      btn = 4'b0001;
      step(1);
      check_eq("second_led", led_echo, 4'b0001);
      btn = 4'b0011;
      step(1);
      check_eq("second_led_keep", led_echo, 4'b0001);
      btn = 4'b0000;
      step(1);
      check_evt("second", 1'b1, 2'd0, 1'b1, 1'b0);
      evt_ack = 1'b1;
      step(1);
      evt_ack = 1'b0;
      enable  = 1'b0;
      step(1);

      // Timeout 8 edges after timer starts
      enable = 1'b1;
      step(7);
      check_eq("tmo_pre_valid", 4'(evt_valid), 4'd0);
      check_eq("tmo_pre_busy",  4'(busy),      4'd0);
      step(1);
      check_evt("tmo", 1'b1, 2'd0, 1'b0, 1'b1);
      evt_ack = 1'b1;
      step(1);
      check_evt("tmo_ack", 1'b0, 2'd0, 1'b0, 1'b0);
      evt_ack = 1'b0;
      step(1);
      check_eq("tmo_rearm", 4'(busy), 4'd0);

      // Press on the timeout edge wins
      step(7);
      btn = 4'b0010;
      step(1);
      check_eq("race_led",     led_echo,        4'b0010);
      check_eq("race_valid",   4'(evt_valid),   4'd0);
      check_eq("race_timeout", 4'(evt_timeout), 4'd0);
      btn = 4'b0000;
      step(1);
      check_evt("race", 1'b1, 2'd1, 1'b0, 1'b0);

      // Ack withheld with button activity during REPORT
      btn = 4'b1111;
      for (int i = 0; i < 20; i++) begin
         step(1);
         check_eq("hold_valid", 4'(evt_valid), 4'd1);
      end
      check_evt("hold_end", 1'b1, 2'd1, 1'b0, 1'b0);
      check_eq("hold_led", led_echo, 4'b0000);
      evt_ack = 1'b1;
      step(1);
      check_eq("held_ack_valid", 4'(evt_valid), 4'd0);
      step(3);
      check_eq("held_waitrel_busy",  4'(busy),      4'd1);
      check_eq("held_waitrel_valid", 4'(evt_valid), 4'd0);
      btn = 4'b0000;
      step(1);
      check_eq("held_rearm", 4'(busy), 4'd0);

      // Ack tied high: exactly one event
      btn = 4'b1000;
      step(1);
      check_eq("tied_led", led_echo, 4'b1000);
      btn = 4'b0000;
      step(1);
      check_evt("tied", 1'b1, 2'd3, 1'b0, 1'b0);
      step(1);
      check_eq("tied_once", 4'(evt_valid), 4'd0);
      step(1);
      check_eq("tied_idle_valid", 4'(evt_valid), 4'd0);
      check_eq("tied_idle_busy",  4'(busy),      4'd0);
      evt_ack = 1'b0;

      // Enable dropped mid-HOLD
      btn = 4'b0100;
      step(1);
      enable = 1'b0;
      step(2);
      check_eq("ena_hold_led", led_echo, 4'b0100);
      btn = 4'b0000;
      step(1);
      check_evt("ena_hold", 1'b1, 2'd2, 1'b0, 1'b0);

      // Reset asserted in REPORT, released with a button held
      #2 rst_n = 1'b0;
      #1;
      check_evt("rst_rep", 1'b0, 2'd0, 1'b0, 1'b0);
      check_eq("rst_rep_busy", 4'(busy), 4'd1);
      btn = 4'b0010;
      step(1);
      rst_n  = 1'b1;
      enable = 1'b1;
      step(3);
      check_eq("rst_held_valid", 4'(evt_valid), 4'd0);
      check_eq("rst_held_busy",  4'(busy),      4'd1);
      check_eq("rst_held_led",   led_echo,      4'b0000);
      btn = 4'b0000;
      step(1);
      check_eq("rst_rearm", 4'(busy), 4'd0);
      btn = 4'b0010;
      step(1);
      check_eq("rst_press_led", led_echo, 4'b0010);
      btn = 4'b0000;
      step(1);
      check_evt("rst_press", 1'b1, 2'd1, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
